hazard_ctrl: RTL

Pipeline hazard and stall controller for the 5-stage RV32I core. It produces the forwarding selects for the Execute-stage ALU operands, plus the stall and flush strobes for the F/D/E/M pipeline registers. It also holds a small state machine that:
- sequences the post-reset pipeline flush;
- freezes the pipe while data memory is not ready.

Saturating stall and flush counters are exported for performance debug.

---
 rtl/hazard_pkg.sv | 17 +
 rtl/sat_counter.sv | 23 ++
 rtl/hazard_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the RV32I hazard/stall controller: forwarding selects and
// controller FSM states.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        STARTUP,
        RUN,
        MEM_WAIT
    } hz_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with async reset. A clear that coincides with an
// increment restarts the count at 1, so the clearing cycle is itself counted.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_o <= '0;
        end else if (clr_i) begin
            cnt_o <= W'(inc_i);
        end else if (inc_i && (cnt_o != {W{1'b1}})) begin
            cnt_o <= cnt_o + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the 5-stage RV32I pipe: operand forwarding,
// load-use and branch handling, startup flush and data-memory wait freeze.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW        = 5,
    parameter int CNT_W         = 32,
    parameter int STARTUP_FLUSH = 2,
    parameter int MAX_WAIT      = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] rs1_d_i,
    input  logic [REG_AW-1:0] rs2_d_i,
    input  logic [REG_AW-1:0] rs1_e_i,
    input  logic [REG_AW-1:0] rs2_e_i,
    input  logic [REG_AW-1:0] rd_e_i,
    input  logic              load_e_i,
    input  logic              pc_src_e_i,
    input  logic [REG_AW-1:0] rd_m_i,
    input  logic              reg_write_m_i,
    input  logic [REG_AW-1:0] rd_w_i,
    input  logic              reg_write_w_i,
    input  logic              dmem_req_m_i,
    input  logic              dmem_ready_i,
    output logic [1:0]        forward_a_e_o,
    output logic [1:0]        forward_b_e_o,
    output logic              stall_f_o,
    output logic              stall_d_o,
    output logic              stall_e_o,
    output logic              stall_m_o,
    output logic              flush_d_o,
    output logic              flush_e_o,
    output logic              flush_w_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o,
    output logic              mem_timeout_o
);

    localparam int               WAIT_W       = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST    = WAIT_W'(MAX_WAIT - 1);
    localparam logic [3:0]        STARTUP_LAST = 4'(STARTUP_FLUSH - 1);

    hz_state_e         state;
    logic [3:0]        startup_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_eff;
    logic              mem_stall;
    logic              lw_stall;

    function automatic fwd_sel_e fwd_pick(input logic [REG_AW-1:0] rs,
                                          input logic [REG_AW-1:0] rd_m,
                                          input logic              we_m,
                                          input logic [REG_AW-1:0] rd_w,
                                          input logic              we_w);
        fwd_sel_e sel;
        sel = FWD_RF;
        if (we_w && (rd_w != '0) && (rd_w == rs)) sel = FWD_W;
        if (we_m && (rd_m != '0) && (rd_m == rs)) sel = FWD_M;
        return sel;
    endfunction

    always_comb begin
        mem_stall = ((state == RUN) && dmem_req_m_i && !dmem_ready_i) ||
                    ((state == MEM_WAIT) && !dmem_ready_i);
        lw_stall  = load_e_i && (rd_e_i != '0) &&
                    ((rd_e_i == rs1_d_i) || (rd_e_i == rs2_d_i));
        // The wait counter is stale in RUN; a fresh wait starts from zero.
        wait_eff  = (state == MEM_WAIT) ? wait_cnt : '0;
    end

    always_comb begin
        forward_a_e_o = FWD_RF;
        forward_b_e_o = FWD_RF;
        stall_f_o     = 1'b0;
        stall_d_o     = 1'b0;
        stall_e_o     = 1'b0;
        stall_m_o     = 1'b0;
        flush_d_o     = 1'b0;
        flush_e_o     = 1'b0;
        flush_w_o     = 1'b0;
        if (state != STARTUP) begin
            forward_a_e_o = fwd_pick(rs1_e_i, rd_m_i, reg_write_m_i, rd_w_i, reg_write_w_i);
            forward_b_e_o = fwd_pick(rs2_e_i, rd_m_i, reg_write_m_i, rd_w_i, reg_write_w_i);
        end
        if (mem_stall) begin
            stall_f_o = 1'b1;
            stall_d_o = 1'b1;
            stall_e_o = 1'b1;
            stall_m_o = 1'b1;
            flush_w_o = 1'b1;
        end else if (state == STARTUP) begin
            stall_f_o = 1'b1;
            flush_d_o = 1'b1;
            flush_e_o = 1'b1;
        end else begin
            stall_f_o = lw_stall;
            stall_d_o = lw_stall;
            flush_e_o = lw_stall || pc_src_e_i;
            flush_d_o = pc_src_e_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= STARTUP;
            startup_cnt   <= '0;
            mem_timeout_o <= 1'b0;
        end else begin
            case (state)
                STARTUP: begin
                    if (startup_cnt == STARTUP_LAST) state <= RUN;
                    else startup_cnt <= startup_cnt + 1'b1;
                end
                RUN:      if (mem_stall) state <= MEM_WAIT;
                MEM_WAIT: if (dmem_ready_i) state <= RUN;
                default:  state <= STARTUP;
            endcase
            if (mem_stall && (wait_eff >= WAIT_LAST)) mem_timeout_o <= 1'b1;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (stall_f_o && (state != STARTUP)),
        .clr_i (1'b0),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (pc_src_e_i && !mem_stall),
        .clr_i (1'b0),
        .cnt_o (flush_cnt_o)
    );

    sat_counter #(.W(WAIT_W)) u_wait_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (mem_stall),
        .clr_i (state != MEM_WAIT),
        .cnt_o (wait_cnt)
    );

endmodule
